snow64_bfloat16_fpu_arbiter: RTL and testbench

Shares one Snow64BFloat16Fpu instance among NUM_REQ requesters, such as vector lanes or issue slots. It accepts one command at a time using round-robin priority and drives the FPU start/oper/a/b port. It waits for FPU completion and returns the result to the owning requester as a one-cycle one-hot response pulse. It sits between the requesters and the FPU; the FPU has no reset and is not modified.

---
 rtl/snow64_bfloat16_fpu_arbiter.sv | 115 +++++++++++
 tb/tb_snow64_bfloat16_fpu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_bfloat16_fpu_arbiter.sv
// snow64_bfloat16_fpu_arbiter: round-robin sharing of one Snow64BFloat16Fpu among NUM_REQ requesters.
// Define SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN to add the WAIT watchdog and the resp_timeout port.
module snow64_bfloat16_fpu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*3-1:0]    req_oper,
   input  logic [NUM_REQ*16-1:0]   req_a,
   input  logic [NUM_REQ*16-1:0]   req_b,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [15:0]             resp_data,
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
   output logic                    resp_timeout,
`endif
   output logic                    busy,
   output logic                    fpu_start,
   output logic [2:0]              fpu_oper,
   output logic [15:0]             fpu_a,
   output logic [15:0]             fpu_b,
   input  logic                    fpu_data_valid,
   input  logic                    fpu_can_accept_cmd,
   input  logic [15:0]             fpu_data
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state;
   logic [IW-1:0] ptr, id, win;
   logic [2:0] win_oper;
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("snow64_bfloat16_fpu_arbiter: parameter out of range");
   end
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
`endif
   // descending scan so the nearest requester at or after ptr wins
   always_comb begin
      win = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_valid[(int'(ptr) + k) % NUM_REQ]) win = IW'((int'(ptr) + k) % NUM_REQ);
      req_ready = (state == IDLE && |req_valid) ? NUM_REQ'(1) << win : '0;
      win_oper = req_oper[win*3 +: 3];
   end
   // fpu_start is registered, so ISSUE raises it from the ready level seen one cycle earlier
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         id <= '0;
         fpu_start <= 1'b0;
         fpu_oper <= '0;
         fpu_a <= '0;
         fpu_b <= '0;
         resp_valid <= '0;
         resp_data <= '0;
         busy <= 1'b0;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
         resp_timeout <= 1'b0;
         cnt <= '0;
`endif
      end else begin
         fpu_start <= 1'b0;
         resp_valid <= '0;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
         resp_timeout <= 1'b0;
`endif
         case (state)
            IDLE: if (|req_valid) begin
               id <= win;
               fpu_oper <= win_oper;
               fpu_a <= req_a[win*16 +: 16];
               fpu_b <= req_b[win*16 +: 16];
               ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
               busy <= 1'b1;
               if (&win_oper[2:1]) begin
                  resp_data <= '0;
                  resp_valid <= req_ready;
                  state <= RESP;
               end else begin
                  fpu_start <= fpu_can_accept_cmd;
                  state <= ISSUE;
               end
            end
            ISSUE: if (fpu_start) begin
               state <= WAIT;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
               cnt <= '0;
`endif
            end else fpu_start <= fpu_can_accept_cmd;
            WAIT: if (fpu_data_valid) begin
               resp_data <= fpu_data;
               resp_valid <= NUM_REQ'(1) << id;
               state <= RESP;
            end
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               resp_data <= '0;
               resp_valid <= NUM_REQ'(1) << id;
               resp_timeout <= 1'b1;
               state <= RESP;
            end else cnt <= cnt + 1'b1;
`endif
            RESP: begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snow64_bfloat16_fpu_arbiter.sv
// tb_snow64_bfloat16_fpu_arbiter: directed and random checks of the arbiter against a transaction-level model.
module tb_snow64_bfloat16_fpu_arbiter;
   localparam int N = 4, TMO = 16;
   logic clk = 0, rst = 1;
   logic [N-1:0] req_valid = '0, req_ready, resp_valid;
   logic [N*3-1:0] req_oper = '0;
   logic [N*16-1:0] req_a = '0, req_b = '0;
   logic [15:0] resp_data, fpu_a, fpu_b, fpu_data;
   logic [2:0] fpu_oper;
   logic busy, fpu_start, fpu_data_valid, fpu_can_accept_cmd;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
   logic resp_timeout;
`endif
   snow64_bfloat16_fpu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
      .resp_timeout(resp_timeout),
`endif
      .busy(busy), .fpu_start(fpu_start), .fpu_oper(fpu_oper), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_data_valid(fpu_data_valid), .fpu_can_accept_cmd(fpu_can_accept_cmd), .fpu_data(fpu_data));
   always #5 clk = ~clk;

   int checks = 0, fails = 0, cyc = 0;
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // FPU stand-in: pinned values for the known bfloat16 cases, arbitrary deterministic results otherwise
   function automatic logic [15:0] fn(logic [2:0] op, logic [15:0] a, logic [15:0] b);
      if (op == 3'd0 && a == 16'h3F80 && b == 16'h4000) return 16'h4040;
      if (op == 3'd3 && a == 16'h4000 && b == 16'h4040) return 16'h40C0;
      case (op)
         3'd2: return {15'd0, a < b};
         3'd0, 3'd5: return a + b;
         3'd1: return a - b;
         3'd3: return a ^ b;
         default: return {a[7:0], b[15:8]};
      endcase
   endfunction

   logic fbusy = 0, fdv = 0;
   logic [15:0] fres = '0, fdata_r = '0;
   int fcnt = 0, fpu_lat = 2;
   bit hang = 0, rnd = 0;
   assign fpu_can_accept_cmd = !fbusy;
   assign fpu_data_valid = fdv;
   assign fpu_data = fdata_r;
   always @(posedge clk) begin
      if (fpu_start && !fbusy) begin
         fbusy <= 1;
         fdv <= 0;
         fres <= fn(fpu_oper, fpu_a, fpu_b);
         fcnt <= rnd ? int'($urandom_range(0, 6)) : fpu_lat;
      end else if (fbusy && !hang) begin
         if (fcnt == 0) begin
            fbusy <= 0;
            fdv <= 1;
            fdata_r <= fres;
         end else fcnt <= fcnt - 1;
      end
   end

   // transaction model: one outstanding command, round-robin pointer, expected response timing
   bit m_busy = 0, m_legal, m_started, m_seen, m_acc;
   int m_id, m_hs, m_st, m_w, ptr = 0, lr_id, lr_lat, starts = 0, resps = 0;
   logic [15:0] m_exp, lr_data;
   logic [34:0] m_args;
   bit lr_tmo;
   logic [N-1:0] waiting = '0;
   int grants[$];

   function automatic int rr(logic [N-1:0] v, int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      int w;
      logic [N-1:0] er;
      bit exp_r, tmo;
      cyc++;
      if (rst) begin
         m_busy = 0;
         ptr = 0;
         waiting = '0;
      end else begin
         w = rr(req_valid, ptr);
         er = (!m_busy && w >= 0) ? N'(1) << w : '0;
         chk("req_ready", req_ready, er);
         chk("busy", busy, m_busy);
         if (m_busy && m_legal && !m_started && m_acc && cyc == m_hs + 1) chk("start_latency", fpu_start, 1);
         if (fpu_start) begin
            starts++;
            chk("start_when_ready", fpu_can_accept_cmd, 1);
            chk("start_owned", m_busy && m_legal && !m_started, 1);
            chk("start_args", {fpu_oper, fpu_a, fpu_b}, m_args);
            m_started = 1;
            m_st = cyc;
         end
         exp_r = m_busy && (!m_legal ? cyc == m_hs + 1 : (m_seen && cyc == m_w + 1));
         tmo = 0;
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
         if (m_busy && m_legal && m_started && !m_seen && cyc == m_st + 1 + TMO) begin
            exp_r = 1;
            tmo = 1;
         end
`endif
         chk("resp_valid", resp_valid, exp_r ? N'(1) << m_id : '0);
         if (exp_r) begin
            chk("resp_data", resp_data, tmo ? 16'h0 : m_exp);
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
            chk("resp_timeout", resp_timeout, tmo);
`endif
            lr_id = m_id; lr_data = resp_data; lr_lat = cyc - m_hs; lr_tmo = tmo;
            resps++;
            waiting[m_id] = 0;
            m_busy = 0;
         end else if (m_busy && m_legal && m_started && !m_seen && cyc > m_st && fpu_data_valid) begin
            m_seen = 1;
            m_w = cyc;
         end
         if (m_busy && cyc - m_hs > 400) begin
            chk("resp_deadline", 0, 1);
            m_busy = 0;
            waiting = '0;
         end
         if (er != 0) begin
            m_id = w; m_hs = cyc; m_started = 0; m_seen = 0; m_acc = fpu_can_accept_cmd;
            m_args = {req_oper[w*3 +: 3], req_a[w*16 +: 16], req_b[w*16 +: 16]};
            m_legal = req_oper[w*3 +: 3] < 3'd6;
            m_exp = m_legal ? fn(req_oper[w*3 +: 3], req_a[w*16 +: 16], req_b[w*16 +: 16]) : 16'h0;
            ptr = (w + 1) % N;
            grants.push_back(w);
            waiting[w] = 1;
            m_busy = 1;
         end
      end
   end

   logic [N-1:0] want = '0;
   logic [2:0] c_op[N];
   logic [15:0] c_a[N], c_b[N];
   task automatic drive();
      want &= ~waiting;
      if (rnd)
         for (int i = 0; i < N; i++)
            if (!want[i] && !waiting[i] && $urandom_range(0, 3) == 0) begin
               want[i] = 1;
               c_op[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
               c_a[i] = 16'($urandom);
               c_b[i] = 16'($urandom);
            end
      req_valid = want;
      for (int i = 0; i < N; i++) begin
         req_oper[i*3 +: 3] = c_op[i];
         req_a[i*16 +: 16] = c_a[i];
         req_b[i*16 +: 16] = c_b[i];
      end
   endtask
   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1 drive();
      end
   endtask
   task automatic issue(int i, logic [2:0] op, logic [15:0] a, logic [15:0] b);
      want[i] = 1; c_op[i] = op; c_a[i] = a; c_b[i] = b;
   endtask
   task automatic wait_done();
      int t = 0;
      do begin
         step(1);
         t++;
      end while ((want != 0 || waiting != 0) && t < 800);
      if (t >= 800) chk("drain_timeout", 0, 1);
   endtask
   task automatic do_reset();
      want = '0;
      @(posedge clk);
      #1 rst = 1;
      drive();
      step(2);
      rst = 0;
   endtask

   initial begin
      int s0, g0, r0, t;
      for (int i = 0; i < N; i++) begin c_op[i] = 0; c_a[i] = 0; c_b[i] = 0; end
      do_reset();
      @(negedge clk);
      #1;
      chk("rst_fpu_start", fpu_start, 0);
      chk("rst_fpu_args", {fpu_oper, fpu_a, fpu_b}, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_busy", busy, 0);
      s0 = starts;
      issue(0, 3'd0, 16'h3F80, 16'h4000);
      wait_done();
      chk("t1_data", lr_data, 16'h4040);
      chk("t1_id", lr_id, 0);
      chk("t1_starts", starts - s0, 1);
      do_reset();
      g0 = grants.size();
      for (int i = 0; i < N; i++) issue(i, 3'd3, 16'h4000, 16'h4040);
      wait_done();
      for (int k = 0; k < N; k++) chk("t2_grant_order", grants[g0 + k], k);
      chk("t2_data", lr_data, 16'h40C0);
      issue(3, 3'd0, 16'h1, 16'h2);
      issue(0, 3'd0, 16'h3, 16'h4);
      wait_done();
      chk("t2_ptr_wrap_first", grants[g0 + N], 0);
      chk("t2_ptr_wrap_second", grants[g0 + N + 1], 3);
      issue(1, 3'd2, 16'h3F80, 16'h4000);
      wait_done();
      chk("t3_slt_lt", lr_data, 16'h0001);
      issue(1, 3'd2, 16'h4000, 16'h3F80);
      wait_done();
      chk("t3_slt_ge", lr_data, 16'h0000);
      s0 = starts;
      issue(2, 3'd7, 16'h1234, 16'h5678);
      wait_done();
      chk("t4_data", lr_data, 16'h0000);
      chk("t4_id", lr_id, 2);
      chk("t4_latency", lr_lat, 1);
      chk("t4_no_start", starts - s0, 0);
      fpu_lat = 20;
      s0 = starts;
      issue(0, 3'd4, 16'h4000, 16'h3F80);
      t = 0;
      while (starts == s0 && t < 50) begin step(1); t++; end
      chk("t5_div_started", starts - s0, 1);
      step(3);
      do_reset();
      fpu_lat = 2;
      r0 = resps;
      issue(1, 3'd0, 16'h3F80, 16'h4000);
      wait_done();
      chk("t5_add_data", lr_data, 16'h4040);
      chk("t5_add_id", lr_id, 1);
      chk("t5_resp_count", resps - r0, 1);
      rnd = 1;
      step(3000);
      rnd = 0;
      wait_done();
`ifdef SNOW64_BFLOAT16_FPU_ARBITER_TIMEOUT_EN
      step(10);
      hang = 1;
      issue(3, 3'd0, 16'h3F80, 16'h4000);
      wait_done();
      chk("t6_timeout_flag", lr_tmo, 1);
      chk("t6_data", lr_data, 16'h0000);
      chk("t6_latency", lr_lat, TMO + 2);
      hang = 0;
`endif
      step(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
